// File: rtl/booth_product_acc.sv
// booth_product_acc
//   Accumulates TERMS consecutive signed products from the booth_multi
//   multiplier into a signed ACC_W-bit sum, presents the result on a
//   registered valid/ready port, then clears for the next group.
//
// Parameters
//   Size  : operand width of the upstream multiplier (product is 2*Size bits)
//   ACC_W : accumulator / result width, ACC_W >= 2*Size
//   TERMS : products summed per result, TERMS >= 1
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_product is valid
//   in_ready   : a product is accepted this cycle (high while accumulating)
//   in_product : signed 2*Size-bit product
//   out_valid  : out_sum / out_ovf hold a completed result
//   out_ready  : downstream consumes the result
//   out_sum    : signed accumulated sum
//   out_ovf    : sticky signed-overflow flag for the group
//
// Build option
//   BOOTH_ACC_SAT_EN : when defined, the accumulator clamps to the signed
//                      range on overflow; otherwise it wraps modulo 2^ACC_W.
module booth_product_acc #(
  parameter int Size  = 4,
  parameter int ACC_W = 16,
  parameter int TERMS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [2*Size-1:0] in_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_ovf
);

  localparam int PROD_W = 2 * Size;
  localparam int CNT_W  = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    ovf_p0;
  logic signed [ACC_W-1:0] sum_p1;
  logic                    ovf_p1;
  logic                    vld_p1;

  logic                    in_fire;
  logic                    out_fire;
  logic                    last_term;
  logic signed [ACC_W:0]   prod_ext;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    ovf_nxt;

`ifdef BOOTH_ACC_SAT_EN
  // The MSB of the one-bit-wider sum is the true sign, so it selects the rail.
  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        saturate = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        saturate = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      saturate = s[ACC_W-1:0];
    end
  endfunction
`endif

  assign vld_p1    = (state == ST_HOLD);
  assign in_ready  = (state == ST_ACC);
  assign out_valid = vld_p1;
  assign out_sum   = sum_p1;
  assign out_ovf   = ovf_p1;

  assign in_fire   = in_valid & (state == ST_ACC);
  assign out_fire  = out_ready & vld_p1;
  assign last_term = (cnt_p0 == LAST_CNT);

  // ---- stage p0: accumulate one product at ACC_W+1 bits ----
  assign prod_ext = {{(ACC_W + 1 - PROD_W){in_product[PROD_W-1]}}, in_product};
  assign acc_ext  = {acc_p0[ACC_W-1], acc_p0};
  assign sum_wide = acc_ext + prod_ext;
  assign add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign ovf_nxt  = ovf_p0 | add_ovf;

  always_comb begin
    acc_nxt = sum_wide[ACC_W-1:0];
`ifdef BOOTH_ACC_SAT_EN
    acc_nxt = saturate(sum_wide);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (in_fire && last_term) state_nxt = ST_HOLD;
      ST_HOLD: if (out_fire)             state_nxt = ST_ACC;
      default:                           state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // The counter holds at TERMS-1 on the final term and clears on the
  // output handshake, so it never leaves 0..TERMS-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
      sum_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (in_fire) begin
      acc_p0 <= acc_nxt;
      ovf_p0 <= ovf_nxt;
      if (last_term) begin
        // ---- stage p1: capture finished group for the output port ----
        sum_p1 <= acc_nxt;
        ovf_p1 <= ovf_nxt;
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end else if (out_fire) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_product_acc.sv
// tb_booth_product_acc
//   Bench for booth_product_acc. Three instances share clock and reset:
//   a_* uses the defaults (ACC_W=16, TERMS=4), b_* uses ACC_W=8, TERMS=4,
//   c_* uses ACC_W=8, TERMS=3. Expected sums come from a plain-integer
//   reference of signed addition with clamp or wrap.
module tb_booth_product_acc;

`ifdef BOOTH_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_ovf;
  logic signed [7:0] a_in_product = '0;
  logic signed [15:0] a_out_sum;

  logic              b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_ovf;
  logic signed [7:0] b_in_product = '0;
  logic signed [7:0] b_out_sum;

  logic              c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_out_ovf;
  logic signed [7:0] c_in_product = '0;
  logic signed [7:0] c_out_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_product_acc #(.Size(4), .ACC_W(16), .TERMS(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_product(a_in_product),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  booth_product_acc #(.Size(4), .ACC_W(8), .TERMS(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  booth_product_acc #(.Size(4), .ACC_W(8), .TERMS(3)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_product(c_in_product),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf)
  );

  // Reference: sum products in an integer, flag any step leaving the
  // signed w-bit range, then clamp or wrap back into range.
  function automatic void ref_group(input int p[$], input int w, output longint s, output bit o);
    longint mx, mn, span;
    mx   = (longint'(1) <<< (w - 1)) - 1;
    mn   = -(longint'(1) <<< (w - 1));
    span = longint'(1) <<< w;
    s = 0;
    o = 1'b0;
    foreach (p[i]) begin
      s = s + p[i];
      if (s > mx || s < mn) begin
        o = 1'b1;
        if (SAT) s = (s > mx) ? mx : mn;
        else     s = (s > mx) ? s - span : s + span;
      end
    end
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_product = 8'sd5;
    b_in_valid = 1'b1; b_in_product = 8'sd7;
    c_in_valid = 1'b1; c_in_product = 8'sd9;
    repeat (2) @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_out_sum !== 16'h0000) begin n_fail++; $display("FAIL reset_out_sum: got %h want 0000", a_out_sum); end
    n_checks++; if (a_out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", a_out_ovf); end
    n_checks++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bc_valid: got %b%b want 00", b_out_valid, c_out_valid); end
    rst_n = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got rdy=%b vld=%b want 1/0", a_in_ready, a_out_valid); end
  endtask

  task automatic test_basic;
    int g1[4] = '{6, -4, 15, -21};
    a_out_ready = 1'b1;
    for (int grp = 0; grp < 2; grp++) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", a_in_ready); end
        a_in_valid = 1'b1;
        a_in_product = (grp == 0) ? 8'(g1[i]) : 8'sd1;
        @(negedge clk);
        if (i < 3) begin
          n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0 term %0d", a_out_valid, i); end
        end
      end
      a_in_valid = 1'b0;
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1", a_out_valid); end
      n_checks++; if (a_out_sum !== ((grp == 0) ? 16'hFFFC : 16'h0004)) begin n_fail++; $display("FAIL basic_sum: got %h want %h", a_out_sum, (grp == 0) ? 16'hFFFC : 16'h0004); end
      n_checks++; if (a_out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", a_out_ovf); end
      n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_ready: got %b want 0", a_in_ready); end
      @(negedge clk);
      n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release: got vld=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
    end
  endtask

  task automatic test_backpressure;
    int g[4] = '{2, 3, 5, 7};
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        repeat (2) begin
          a_in_valid = 1'b0;
          @(negedge clk);
          n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_bubble_valid: got %b want 0", a_out_valid); end
        end
      end
      a_in_valid = 1'b1; a_in_product = 8'(g[i]);
      @(negedge clk);
    end
    // A product offered during HOLD must be ignored.
    a_in_valid = 1'b1; a_in_product = 8'sd9;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1 cycle %0d", a_out_valid, k); end
      n_checks++; if (a_out_sum !== 16'd17) begin n_fail++; $display("FAIL bp_hold_sum: got %0d want 17 cycle %0d", a_out_sum, k); end
      n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %b want 0 cycle %0d", a_in_ready, k); end
      @(negedge clk);
    end
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_end: got %b want 1", a_out_valid); end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
    // Resume immediately: 1,2,3,4 must give 10 if the held 9 was dropped.
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1'b1; a_in_product = 8'(i);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b1 || a_out_sum !== 16'd10) begin n_fail++; $display("FAIL bp_resume: got vld=%b sum=%0d want 1/10", a_out_valid, a_out_sum); end
    @(negedge clk);
  endtask

  task automatic test_random_a;
    int q[$];
    longint es;
    bit eo;
    int k;
    a_out_ready = 1'b0;
    for (int g = 0; g < 25; g++) begin
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(int'($urandom_range(0, 255)) - 128);
      ref_group(q, 16, es, eo);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          a_in_valid = 1'b0;
          @(negedge clk);
          n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_a_bubble: got %b want 0", a_out_valid); end
        end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_a_ready: got %b want 1", a_in_ready); end
        a_in_valid = 1'b1; a_in_product = 8'(q[i]);
        @(negedge clk);
      end
      a_in_valid = 1'b0;
      k = int'($urandom_range(0, 2));
      for (int c = 0; c <= k; c++) begin
        n_checks++; if (a_out_valid !== 1'b1 || a_out_sum !== 16'(es) || a_out_ovf !== eo) begin
          n_fail++; $display("FAIL rnd_a_result: got vld=%b sum=%0d ovf=%b want 1/%0d/%b group %0d", a_out_valid, a_out_sum, a_out_ovf, es, eo, g);
        end
        if (c < k) @(negedge clk);
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_a_release: got %b want 0", a_out_valid); end
    end
  endtask

  task automatic test_overflow;
    int g[4] = '{64, 64, 0, 0};
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_in_ready: got %b want 1", b_in_ready); end
      b_in_valid = 1'b1; b_in_product = 8'(g[i]);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", b_out_valid); end
    n_checks++; if (b_out_sum !== (SAT ? 8'h7F : 8'h80)) begin n_fail++; $display("FAIL ovf_sum: got %h want %h", b_out_sum, SAT ? 8'h7F : 8'h80); end
    n_checks++; if (b_out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", b_out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_neg_overflow;
    c_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL negovf_in_ready: got %b want 1", c_in_ready); end
      c_in_valid = 1'b1; c_in_product = -8'sd56;
      @(negedge clk);
      if (i < 2) begin
        n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL negovf_early: got %b want 0", c_out_valid); end
      end
    end
    c_in_valid = 1'b0;
    n_checks++; if (c_out_valid !== 1'b1) begin n_fail++; $display("FAIL negovf_valid: got %b want 1", c_out_valid); end
    n_checks++; if (c_out_sum !== (SAT ? 8'h80 : 8'd88)) begin n_fail++; $display("FAIL negovf_sum: got %0d want %0d", c_out_sum, SAT ? -128 : 88); end
    n_checks++; if (c_out_ovf !== 1'b1) begin n_fail++; $display("FAIL negovf_flag: got %b want 1", c_out_ovf); end
    @(negedge clk);
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL negovf_release: got %b want 0", c_out_valid); end
  endtask

  task automatic test_random_b;
    int q[$];
    longint es;
    bit eo;
    b_out_ready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(int'($urandom_range(0, 255)) - 128);
      ref_group(q, 8, es, eo);
      for (int i = 0; i < 4; i++) begin
        b_in_valid = 1'b1; b_in_product = 8'(q[i]);
        @(negedge clk);
      end
      b_in_valid = 1'b0;
      n_checks++; if (b_out_valid !== 1'b1 || b_out_sum !== 8'(es) || b_out_ovf !== eo) begin
        n_fail++; $display("FAIL rnd_b_result: got vld=%b sum=%0d ovf=%b want 1/%0d/%b group %0d", b_out_valid, b_out_sum, b_out_ovf, es, eo, g);
      end
      @(negedge clk);
      n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_b_release: got %b want 0", b_out_valid); end
    end
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_product = 8'sd10;
    @(negedge clk);
    a_in_product = 8'sd20;
    @(negedge clk);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got rdy=%b vld=%b want 1/0", a_in_ready, a_out_valid); end
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1'b1; a_in_product = 8'(i);
      @(negedge clk);
      if (i < 4) begin
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early: got %b want 0 after term %0d", a_out_valid, i); end
      end
    end
    a_in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b1 || a_out_sum !== 16'd10 || a_out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL midrst_result: got vld=%b sum=%0d ovf=%b want 1/10/0", a_out_valid, a_out_sum, a_out_ovf);
    end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_single: got %b want 0", a_out_valid); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_a();
    test_overflow();
    test_neg_overflow();
    test_random_b();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
